moon_boss_ctrl: RTL
===================

# moon_boss_ctrl

Phase sequencer for the moon boss sprite. It owns the motion tick, tells the moon position datapath when to load and when to step on each axis, and sets each step's direction. It also runs the boss HP and invulnerability counters and the visibility/blink gating consumed by the pixel mixer. It sits between the collision logic (hit pulses, player position) and the moon position/sprite block.

## Interface
- TICK_DIV, 500000: clocks per motion tick.
- DWELL_TICKS, 200: ticks parked at a border.
- HP_INIT, 32: boss HP loaded on start (1..255).
- IFRAME_TICKS, 50: invulnerability ticks after an accepted hit.
- DEATH_TICKS, 128: ticks in dying animation.
- START_X, 192 / ENTRY_Y, 100: spawn x; y at which entry ends.
- X_MIN 64, X_MAX 320, Y_MIN 64, Y_MAX 384: border box.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- start  in  1  one-cycle request to (re)start the boss.
- hit  in  1  one-cycle pulse: player shot overlapped moon.
- moon_x, moon_y  in  10  current moon centre.
- player_x, player_y  in  10  current player position.
- load_pos  out  1  one-cycle pulse: datapath loads (load_x, load_y).
- load_x, load_y  out  10  constant START_X, 0.
- step_x, step_y  out  1  one-cycle step enables (move 1 px).
- dir_x, dir_y  out  1  step direction: 1 = +1, 0 = −1.
- tick  out  1  one-cycle motion strobe.
- moon_visible  out  1  sprite may be drawn.
- boss_hp  out  8  remaining HP.
- state  out  3  current phase code.
- boss_dead  out  1  high in DONE.

## Operation
- Prescaler: 0..TICK_DIV−1, free-running. tick is registered, high for the cycle after count==TICK_DIV−1.
- on_border = moon_x≤X_MIN | moon_x≥X_MAX | moon_y≤Y_MIN | moon_y≥Y_MAX.
- Relatch: dir_x = (moon_x<player_x), dir_y = (moon_y<player_y). Then force away from a border: x≤X_MIN→dir_x=1, x≥X_MAX→dir_x=0, same rule for y.
- States:
  - IDLE(0): on start → ENTER. Assert load_pos next cycle. boss_hp=HP_INIT. Clear iframe.
  - ENTER(1): on tick, step_y=1 with dir_y=1 and step_x=0. At a tick with moon_y≥ENTRY_Y: relatch, clear the moved flag, go to CHASE with no step that tick.
  - CHASE(2): on tick, step_x=step_y=1 and set the moved flag. At a tick with on_border and moved=1: go to DWELL with no step, clear dwell_cnt.
  - DWELL(3): no steps. Count ticks. When dwell_cnt reaches DWELL_TICKS: relatch, clear moved, go to CHASE. The step fires on the next tick.
  - DYING(4): no steps. Count ticks. At DEATH_TICKS go to DONE.
  - DONE(5): boss_dead=1. On start, behaves as IDLE's start.
- step_x and step_y are the combinational AND of tick and state. Directions are held between relatches.
- Hit handling:
  - A hit is accepted only in CHASE/DWELL with iframe_cnt==0.
  - An accepted hit decrements boss_hp and loads iframe_cnt=IFRAME_TICKS.
  - iframe_cnt decrements on each tick while nonzero.
  - If boss_hp goes 1→0: next state is DYING, overriding any same-cycle border/dwell transition.
- moon_visible:
  - IDLE/DONE: 0.
  - ENTER/CHASE/DWELL: iframe_cnt==0 | iframe_cnt[2].
  - DYING: death_cnt[3].
- start is ignored outside IDLE/DONE. Hits are ignored outside CHASE/DWELL.

## Timing
- Reset (async) sets:
  - state=IDLE, prescaler=0, all counters=0, moved=0.
  - boss_hp=0, dir_x=dir_y=1.
  - tick=step_x=step_y=load_pos=moon_visible=boss_dead=0.
- A reset mid-phase aborts immediately; no load or step is emitted.
- start sampled at edge N: state=ENTER at N+1, load_pos high for exactly cycle N+1.
- Transitions and counter updates happen on the edge that samples tick=1. moon_x/moon_y are read on that same edge.
- boss_hp updates on the edge after the hit cycle. hit and tick in the same cycle: the iframe reload wins over the tick decrement.
- hit on the cycle the state enters CHASE/DWELL counts. hit coinciding with the DYING transition is ignored.
- Counters saturate and never wrap. boss_hp never decrements below 0.

## Test plan
- TICK_DIV=4: after reset, tick pulses every 4 clocks; step_x/step_y/load_pos stay 0 in IDLE.
- start with moon_y driven from 0 by a model: load_pos 1 cycle, ENTER steps y up only. At moon_y=100, dir latched toward player (player 300,400 → dir_x=1, dir_y=1), state=CHASE.
- CHASE reaches moon_x=320: DWELL for exactly DWELL_TICKS ticks with no steps. Exit with dir_x=0 even if player_x=350.
- HP_INIT=2, IFRAME_TICKS=8:
  - hit → hp=1; second hit within 8 ticks ignored.
  - hit after iframe expiry → hp=0, DYING, then DONE after DEATH_TICKS with boss_dead=1.
- hit coinciding with the border tick: hp decrements and the DWELL entry still occurs. Blink pattern follows iframe_cnt[2].
- Assert reset mid-DWELL: all outputs take reset values asynchronously. A following start restarts cleanly with hp=HP_INIT.

Source files
------------

// File: rtl/moon_boss_ctrl_if.sv
// Signal bundle between the moon boss phase sequencer and its surroundings
// (collision logic on one side, moon position/sprite datapath on the other).
interface moon_boss_ctrl_if;
   logic       start;
   logic       hit;
   logic [9:0] moon_x;
   logic [9:0] moon_y;
   logic [9:0] player_x;
   logic [9:0] player_y;
   logic       load_pos;
   logic [9:0] load_x;
   logic [9:0] load_y;
   logic       step_x;
   logic       step_y;
   logic       dir_x;
   logic       dir_y;
   logic       tick;
   logic       moon_visible;
   logic [7:0] boss_hp;
   logic [2:0] state;
   logic       boss_dead;

   modport master (
      input  start, hit, moon_x, moon_y, player_x, player_y,
      output load_pos, load_x, load_y, step_x, step_y, dir_x, dir_y,
             tick, moon_visible, boss_hp, state, boss_dead
   );

   modport slave (
      output start, hit, moon_x, moon_y, player_x, player_y,
      input  load_pos, load_x, load_y, step_x, step_y, dir_x, dir_y,
             tick, moon_visible, boss_hp, state, boss_dead
   );
endinterface

// File: rtl/moon_boss_ctrl.sv
// Moon boss phase sequencer: motion tick, entry/chase/dwell stepping,
// HP and invulnerability tracking, and sprite visibility/blink gating.
module moon_boss_ctrl #(
   parameter int unsigned TICK_DIV     = 500000,
   parameter int unsigned DWELL_TICKS  = 200,
   parameter int unsigned HP_INIT      = 32,
   parameter int unsigned IFRAME_TICKS = 50,
   parameter int unsigned DEATH_TICKS  = 128,
   parameter int unsigned START_X      = 192,
   parameter int unsigned ENTRY_Y      = 100,
   parameter int unsigned X_MIN        = 64,
   parameter int unsigned X_MAX        = 320,
   parameter int unsigned Y_MIN        = 64,
   parameter int unsigned Y_MAX        = 384
) (
   input  logic             clk,
   input  logic             reset,
   moon_boss_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ENTER = 3'd1,
      S_CHASE = 3'd2,
      S_DWELL = 3'd3,
      S_DYING = 3'd4,
      S_DONE  = 3'd5
   } state_e;

   localparam int unsigned PSC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CW    = 16;

   state_e           state_q;
   logic [PSC_W-1:0] psc_q;
   logic             tick_q;
   logic             load_q;
   logic             moved_q;
   logic             dir_x_q;
   logic             dir_y_q;
   logic [CW-1:0]    dwell_q;
   logic [CW-1:0]    death_q;
   logic [CW-1:0]    ifr_q;
   logic [7:0]       hp_q;

   logic on_border, park, start_ok, hit_ok, rdx, rdy;

   always_comb begin
      on_border = (bus.moon_x <= 10'(X_MIN)) | (bus.moon_x >= 10'(X_MAX)) |
                  (bus.moon_y <= 10'(Y_MIN)) | (bus.moon_y >= 10'(Y_MAX));
      park      = on_border & moved_q;
      start_ok  = bus.start & ((state_q == S_IDLE) | (state_q == S_DONE));
      hit_ok    = bus.hit & ((state_q == S_CHASE) | (state_q == S_DWELL)) & (ifr_q == '0);
      // Aim at the player, but a border always pushes the moon back inside.
      rdx = (bus.moon_x < bus.player_x);
      if (bus.moon_x <= 10'(X_MIN))      rdx = 1'b1;
      else if (bus.moon_x >= 10'(X_MAX)) rdx = 1'b0;
      rdy = (bus.moon_y < bus.player_y);
      if (bus.moon_y <= 10'(Y_MIN))      rdy = 1'b1;
      else if (bus.moon_y >= 10'(Y_MAX)) rdy = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         psc_q  <= '0;
         tick_q <= 1'b0;
      end else if (psc_q == PSC_W'(TICK_DIV - 1)) begin
         psc_q  <= '0;
         tick_q <= 1'b1;
      end else begin
         psc_q  <= psc_q + PSC_W'(1);
         tick_q <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         load_q  <= 1'b0;
         moved_q <= 1'b0;
         dir_x_q <= 1'b1;
         dir_y_q <= 1'b1;
         dwell_q <= '0;
         death_q <= '0;
         ifr_q   <= '0;
         hp_q    <= '0;
      end else begin
         load_q <= start_ok;
         if (start_ok) begin
            state_q <= S_ENTER;
            hp_q    <= 8'(HP_INIT);
            ifr_q   <= '0;
            moved_q <= 1'b0;
            dir_x_q <= 1'b1;
            dir_y_q <= 1'b1;
            dwell_q <= '0;
            death_q <= '0;
         end else begin
            if (tick_q) begin
               case (state_q)
                  S_ENTER: if (bus.moon_y >= 10'(ENTRY_Y)) begin
                     dir_x_q <= rdx;
                     dir_y_q <= rdy;
                     moved_q <= 1'b0;
                     state_q <= S_CHASE;
                  end
                  S_CHASE: if (park) begin
                     state_q <= S_DWELL;
                     dwell_q <= '0;
                  end else begin
                     moved_q <= 1'b1;
                  end
                  S_DWELL: if (dwell_q == CW'(DWELL_TICKS - 1)) begin
                     dir_x_q <= rdx;
                     dir_y_q <= rdy;
                     moved_q <= 1'b0;
                     state_q <= S_CHASE;
                  end else if (dwell_q != '1) begin
                     dwell_q <= dwell_q + CW'(1);
                  end
                  S_DYING: begin
                     if (death_q == CW'(DEATH_TICKS - 1)) state_q <= S_DONE;
                     if (death_q != '1) death_q <= death_q + CW'(1);
                  end
                  default: ;
               endcase
            end
            // Last HP overrides whatever phase change the tick requested.
            if (hit_ok) begin
               ifr_q <= CW'(IFRAME_TICKS);
               if (hp_q != '0) hp_q <= hp_q - 8'd1;
               if (hp_q == 8'd1) begin
                  state_q <= S_DYING;
                  death_q <= '0;
               end
            end else if (tick_q && (ifr_q != '0)) begin
               ifr_q <= ifr_q - CW'(1);
            end
         end
      end
   end

   always_comb begin
      bus.moon_visible = 1'b0;
      case (state_q)
         S_ENTER, S_CHASE, S_DWELL: bus.moon_visible = (ifr_q == '0) | ifr_q[2];
         S_DYING:                   bus.moon_visible = death_q[3];
         default:                   bus.moon_visible = 1'b0;
      endcase
   end

   assign bus.tick      = tick_q;
   assign bus.load_pos  = load_q;
   assign bus.load_x    = 10'(START_X);
   assign bus.load_y    = '0;
   assign bus.step_x    = tick_q & (state_q == S_CHASE) & ~park;
   assign bus.step_y    = tick_q & (((state_q == S_ENTER) & (bus.moon_y < 10'(ENTRY_Y))) |
                                    ((state_q == S_CHASE) & ~park));
   assign bus.dir_x     = dir_x_q;
   assign bus.dir_y     = dir_y_q;
   assign bus.boss_hp   = hp_q;
   assign bus.state     = state_q;
   assign bus.boss_dead = (state_q == S_DONE);

endmodule
